uncached_write_buffer: RTL
==========================

UNCACHED_WRITE_BUFFER -- requirements
Module: uncached_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of posted uncached write entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port dreq  input  dbus_req_t  uncached data request from core-side mux (valid, addr, size, strobe, data).
REQ-005 SHALL have port dresp  output  dbus_resp_t  response to core (addr_ok, data_ok, data).
REQ-006 SHALL have port dcreq  output  cbus_req_t  request toward arbiter (valid, is_write, size, addr, strobe, data, len).
REQ-007 SHALL have port dcresp  input  cbus_resp_t  arbiter response (ready, last, data).

Function
REQ-008 SHALL classify a request as a write when dreq.valid=1 and dreq.strobe!=0, and as a read when dreq.valid=1 and dreq.strobe=0.
REQ-009 SHALL hold a FIFO of DEPTH entries {addr, size, strobe, data}, with head/tail pointers wrapping modulo DEPTH and a count of width clog2(DEPTH)+1.
REQ-010 SHALL accept a write when the FIFO is not full and no read is in flight: in that cycle it asserts dresp.addr_ok=1 and dresp.data_ok=1 combinationally and pushes the entry at the next edge (posted write, 0-cycle latency).
REQ-011 SHALL NOT accept a write when full, keeping addr_ok=data_ok=0, even if a pop completes in the same cycle; the write is accepted on the following cycle.
REQ-012 SHALL use an FSM with states IDLE, DRAIN, and READ.
REQ-013 In IDLE with count>0, the FSM SHALL go to DRAIN next cycle.
REQ-014 In DRAIN, SHALL drive dcreq.valid=1, is_write=1, len=single beat (MLEN1), and addr/size/strobe/data from the FIFO head, held stable until dcresp.ready&&dcresp.last.
REQ-015 On that DRAIN handshake, SHALL pop the head; the FSM SHALL stay in DRAIN if count after pop >0, otherwise go to IDLE.
REQ-016 SHALL keep a read pending (addr_ok=0) while count>0 or state!=IDLE, so that reads never bypass older buffered writes.
REQ-017 In IDLE with count=0 and a read present, SHALL assert dresp.addr_ok=1, latch addr/size, and enter READ.
REQ-018 In READ, SHALL drive dcreq.valid=1, is_write=0, strobe=0, len=MLEN1, with the latched addr/size.
REQ-019 On dcresp.ready&&dcresp.last in READ, SHALL assert dresp.data_ok=1 with dresp.data=dcresp.data in the same cycle and return to IDLE; addr_ok SHALL be 0 throughout READ.
REQ-020 SHALL allow a simultaneous push (accepted write) and pop (drain completion): count unchanged, both pointers advance.
REQ-021 SHALL keep dcreq.valid=0 and all dcreq fields at 0 in IDLE.
REQ-022 SHALL pass addresses through untranslated; address translation happens downstream.
REQ-023 SHALL treat dcresp.ready without dcresp.last as a no-op (single-beat only).

Reset
REQ-024 When reset=1 at an edge, SHALL set state=IDLE, count=0, head=tail=0, and clear the latched read.
REQ-025 While reset=1, SHALL drive dcreq all zero and dresp all zero.
REQ-026 Reset asserted mid-DRAIN or mid-READ SHALL abandon the transaction: buffered writes are discarded and no data_ok is issued.

Verification
REQ-027 Single write 0xBFD0_0000, strobe 4'hF, data 0x1234_5678 -> addr_ok=data_ok=1 the same cycle; one cycle later dcreq.valid=1, is_write=1, with the same addr/data; count returns to 0 after ready&last.
REQ-028 Five back-to-back writes with DEPTH=4 and arbiter ready held low -> first four accepted on consecutive cycles, fifth held with addr_ok=0 until the first drain handshake, then accepted one cycle later.
REQ-029 Write to 0xBFAF_0000 followed immediately by a read of the same address -> read addr_ok stays 0 until the write's ready&last; read then issues, and data_ok returns dcresp.data (e.g. 0xCAFE_F00D) on last.
REQ-030 FIFO wrap: 10 writes with a one-cycle drain each -> dcreq addresses appear in exact issue order across a pointer wrap, with no loss or duplication.
REQ-031 Push and pop in the same cycle at count=2 -> count stays 2 and drain order is preserved.
REQ-032 Reset asserted during READ with 3 queued-then-drained writes -> the next cycle shows state IDLE, dcreq.valid=0, no data_ok, and a new write is accepted immediately.

Source files
------------

// File: rtl/uncached_write_buffer_if.sv
// Bus types and the core/arbiter signal bundle shared by the uncached write buffer and its neighbours.
// Field widths: 32-bit address and data, 4-bit byte strobe, 3-bit size, 4-bit burst length.
package uncached_write_buffer_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  strobe_t;
    typedef logic [2:0]  msize_t;
    typedef logic [3:0]  mlen_t;

    // A single-beat transfer is encoded as burst length zero.
    localparam mlen_t MLEN1 = 4'd0;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic    valid;
        logic    is_write;
        msize_t  size;
        addr_t   addr;
        strobe_t strobe;
        word_t   data;
        mlen_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;
endpackage

interface uncached_write_buffer_if;
    import uncached_write_buffer_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  dcreq;
    cbus_resp_t dcresp;

    // The master side is the core plus the arbiter; the slave side is the buffer.
    modport master (output dreq, input dresp, input dcreq, output dcresp);
    modport slave  (input dreq, output dresp, output dcreq, input dcresp);
endinterface

// File: rtl/uncached_write_buffer.sv
// Posted uncached write buffer: writes complete to the core at once and drain to the arbiter in order;
// reads wait until every older write has drained so they can never overtake one.
module uncached_write_buffer
    import uncached_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    uncached_write_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    typedef struct packed {
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } entry_t;

    entry_t        fifo [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [1:0]    state;
    logic [1:0]    state_next;
    addr_t         read_addr;
    msize_t        read_size;

    logic is_write_req;
    logic is_read_req;
    logic full;
    logic push;
    logic pop;
    logic read_accept;
    logic read_done;

    // Full blocks a write even when a pop lands in the same cycle, keeping the accept path off dcresp.
    always_comb begin
        is_write_req = bus.dreq.valid && (bus.dreq.strobe != '0);
        is_read_req  = bus.dreq.valid && (bus.dreq.strobe == '0);
        full         = (count == CW'(DEPTH));
        push         = !reset && is_write_req && !full && (state != READ);
        pop          = !reset && (state == DRAIN) && bus.dcresp.ready && bus.dcresp.last;
        read_accept  = !reset && (state == IDLE) && (count == '0) && is_read_req;
        read_done    = !reset && (state == READ) && bus.dcresp.ready && bus.dcresp.last;

        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Leaving IDLE looks at the post-push count so a lone write reaches the arbiter one cycle after acceptance.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count_next != '0) begin
                    state_next = DRAIN;
                end else if (read_accept) begin
                    state_next = READ;
                end
            end
            DRAIN: begin
                if (pop && (count_next == '0)) begin
                    state_next = IDLE;
                end
            end
            READ: begin
                if (read_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            read_addr <= '0;
            read_size <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (read_accept) begin
                read_addr <= bus.dreq.addr;
                read_size <= bus.dreq.size;
            end
        end
    end

    // Storage needs no reset: an entry is only read after its push, and push is suppressed during reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[tail] <= '{addr:   bus.dreq.addr,
                            size:   bus.dreq.size,
                            strobe: bus.dreq.strobe,
                            data:   bus.dreq.data};
        end
    end

    always_comb begin
        bus.dresp         = '0;
        bus.dresp.addr_ok = push || read_accept;
        bus.dresp.data_ok = push || read_done;
        bus.dresp.data    = read_done ? bus.dcresp.data : '0;

        bus.dcreq = '0;
        if (!reset) begin
            case (state)
                DRAIN: begin
                    bus.dcreq.valid    = 1'b1;
                    bus.dcreq.is_write = 1'b1;
                    bus.dcreq.size     = fifo[head].size;
                    bus.dcreq.addr     = fifo[head].addr;
                    bus.dcreq.strobe   = fifo[head].strobe;
                    bus.dcreq.data     = fifo[head].data;
                    bus.dcreq.len      = MLEN1;
                end
                READ: begin
                    bus.dcreq.valid    = 1'b1;
                    bus.dcreq.is_write = 1'b0;
                    bus.dcreq.size     = read_size;
                    bus.dcreq.addr     = read_addr;
                    bus.dcreq.strobe   = '0;
                    bus.dcreq.len      = MLEN1;
                end
                default: bus.dcreq = '0;
            endcase
        end
    end

endmodule
